// File: rtl/chip8_vga_scanout.sv
// CHIP-8 display back-end: 640x480@60 VGA timing, scaled 64x32 frame buffer
// read one row per line from the VRAM read port into a line buffer during hblank.
module chip8_vga_scanout #(
  parameter int          H_VISIBLE = 640,
  parameter int          H_FRONT   = 16,
  parameter int          H_SYNC    = 96,
  parameter int          H_BACK    = 48,
  parameter int          V_VISIBLE = 480,
  parameter int          V_FRONT   = 10,
  parameter int          V_SYNC    = 2,
  parameter int          V_BACK    = 33,
  parameter int          SCALE     = 10,
  parameter int          V_OFFSET  = 80,
  parameter logic [11:0] FG_COLOR  = 12'hFFF,
  parameter logic [11:0] BG_COLOR  = 12'h000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [63:0] vram_data_in,
  output logic [4:0]  vram_address_out,
  output logic        hsync,
  output logic        vsync,
  output logic [11:0] rgb,
  output logic        active,
  output logic        frame_start
);
  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int SW      = (SCALE > 1) ? $clog2(SCALE) : 1;

  localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_VIS   = HW'(H_VISIBLE);
  localparam logic [HW-1:0] H_FETCH = HW'(H_VISIBLE + 1);
  localparam logic [HW-1:0] H_WIN   = HW'(64 * SCALE);
  localparam logic [HW-1:0] HS_BEG  = HW'(H_VISIBLE + H_FRONT);
  localparam logic [HW-1:0] HS_END  = HW'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_VIS   = VW'(V_VISIBLE);
  localparam logic [VW-1:0] V_WIN0  = VW'(V_OFFSET);
  localparam logic [VW-1:0] V_WIN1  = VW'(V_OFFSET + 32 * SCALE);
  localparam logic [VW-1:0] VS_BEG  = VW'(V_VISIBLE + V_FRONT);
  localparam logic [VW-1:0] VS_END  = VW'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [SW-1:0] S_LAST  = SW'(SCALE - 1);

  logic [HW-1:0] h;
  logic [VW-1:0] v, v_next;
  logic [5:0]    col;
  logic [4:0]    row, fetch_row;
  logic [SW-1:0] sx, sy;
  logic [63:0]   line_buf;
  logic          h_last, v_in_win, vn_in_win, h_in_win, visible, pixel_on;

  always_comb begin
    h_last    = (h == H_LAST);
    v_next    = (v == V_LAST) ? '0 : v + 1'b1;
    v_in_win  = (v >= V_WIN0) && (v < V_WIN1);
    vn_in_win = (v_next >= V_WIN0) && (v_next < V_WIN1);
    h_in_win  = (h < H_WIN);
    visible   = (h < H_VIS) && (v < V_VIS);
    pixel_on  = h_in_win && v_in_win && line_buf[col];
    // Row of the line after this one, derived from the running row/sy counters.
    fetch_row = 5'd0;
    if (vn_in_win)
      fetch_row = (v_in_win && sy == S_LAST) ? row + 5'd1 : row;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      h <= '0;
      v <= '0;
    end else if (h_last) begin
      h <= '0;
      v <= v_next;
    end else begin
      h <= h + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      col <= '0;
      sx  <= '0;
    end else if (h_last) begin
      col <= '0;
      sx  <= '0;
    end else if (h_in_win) begin
      if (sx == S_LAST) begin
        sx  <= '0;
        col <= col + 6'd1;
      end else begin
        sx <= sx + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      row <= '0;
      sy  <= '0;
    end else if (h_last) begin
      if (v_in_win && vn_in_win) begin
        if (sy == S_LAST) begin
          sy  <= '0;
          row <= row + 5'd1;
        end else begin
          sy <= sy + 1'b1;
        end
      end else begin
        row <= '0;
        sy  <= '0;
      end
    end
  end

  // vram_address_out doubles as the read port's address register; data is
  // valid the following cycle and latched for the whole next line.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vram_address_out <= '0;
      line_buf         <= '0;
    end else begin
      if (h == H_VIS)   vram_address_out <= fetch_row;
      if (h == H_FETCH) line_buf         <= vram_data_in;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      rgb         <= '0;
      active      <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      hsync       <= !((h >= HS_BEG) && (h < HS_END));
      vsync       <= !((v >= VS_BEG) && (v < VS_END));
      active      <= visible;
      frame_start <= (h == '0) && (v == '0);
      rgb         <= !visible ? 12'h000 : (pixel_on ? FG_COLOR : BG_COLOR);
    end
  end
endmodule

// File: tb/tb_chip8_vga_scanout.sv
// Randomized self-checking bench for chip8_vga_scanout on a shrunken timing
// geometry, compared cycle by cycle against a position-based reference model.
module tb_chip8_vga_scanout;
  localparam int HV = 160, HF = 4, HS = 8, HB = 8;
  localparam int VV = 80,  VF = 2, VS = 2, VB = 3;
  localparam int SC = 2,   VO = 8;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam logic [11:0] FG = 12'hA5C;
  localparam logic [11:0] BG = 12'h123;

  logic        clock = 1'b0;
  logic        reset;
  logic [63:0] vram_data_in;
  logic [4:0]  vram_address_out;
  logic        hsync, vsync, active, frame_start;
  logic [11:0] rgb;

  logic [63:0] mem  [0:31];
  logic [63:0] snap [0:VT-1];
  logic [4:0]  ea;
  int          p;
  int          errors = 0, checks = 0;
  int          act_cnt, hs_low, vs_low, fg_cnt;
  int          fs_pos[$];

  chip8_vga_scanout #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .SCALE(SC), .V_OFFSET(VO), .FG_COLOR(FG), .BG_COLOR(BG)
  ) dut (
    .clock(clock), .reset(reset), .vram_data_in(vram_data_in),
    .vram_address_out(vram_address_out), .hsync(hsync), .vsync(vsync),
    .rgb(rgb), .active(active), .frame_start(frame_start)
  );

  always #5 clock = ~clock;
  assign vram_data_in = mem[vram_address_out];

  task automatic model_reset();
    p  = 0;
    ea = 5'd0;
    for (int i = 0; i < VT; i++) snap[i] = 64'd0;
  endtask

  task automatic clear_counts();
    act_cnt = 0; hs_low = 0; vs_low = 0; fg_cnt = 0;
    fs_pos.delete();
  endtask

  // Position p = index of the registered output sample since reset release.
  task automatic scan(input int n, input int wr_v, input int wr_row,
                      input logic [63:0] wr_val, input string tag);
    int    h, v, vn;
    logic  e_hs, e_vs, e_act, e_fs, win;
    logic [11:0] e_rgb;
    int    bad[6];
    string first[6];
    string nm[6];
    nm = '{"hsync", "vsync", "active", "frame_start", "rgb", "address"};
    for (int k = 0; k < 6; k++) begin bad[k] = 0; first[k] = ""; end
    for (int i = 0; i < n; i++) begin
      @(posedge clock); #1;
      h = p % HT;
      v = (p / HT) % VT;
      if (h == HV) begin
        vn = (v + 1) % VT;
        if (vn >= VO && vn < VO + 32 * SC) begin
          snap[vn] = mem[(vn - VO) / SC];
          ea = 5'((vn - VO) / SC);
        end else begin
          ea = 5'd0;
        end
      end
      e_hs  = !(h >= HV + HF && h < HV + HF + HS);
      e_vs  = !(v >= VV + VF && v < VV + VF + VS);
      e_act = (h < HV) && (v < VV);
      e_fs  = (h == 0) && (v == 0);
      win   = (v >= VO) && (v < VO + 32 * SC) && (h < 64 * SC);
      e_rgb = !e_act ? 12'h000 : ((win && snap[v][h / SC]) ? FG : BG);
      if (hsync !== e_hs) begin
        if (bad[0] == 0) first[0] = $sformatf("h=%0d v=%0d got %b want %b", h, v, hsync, e_hs);
        bad[0]++;
      end
      if (vsync !== e_vs) begin
        if (bad[1] == 0) first[1] = $sformatf("h=%0d v=%0d got %b want %b", h, v, vsync, e_vs);
        bad[1]++;
      end
      if (active !== e_act) begin
        if (bad[2] == 0) first[2] = $sformatf("h=%0d v=%0d got %b want %b", h, v, active, e_act);
        bad[2]++;
      end
      if (frame_start !== e_fs) begin
        if (bad[3] == 0) first[3] = $sformatf("h=%0d v=%0d got %b want %b", h, v, frame_start, e_fs);
        bad[3]++;
      end
      if (rgb !== e_rgb) begin
        if (bad[4] == 0) first[4] = $sformatf("h=%0d v=%0d got %h want %h", h, v, rgb, e_rgb);
        bad[4]++;
      end
      if (vram_address_out !== ea) begin
        if (bad[5] == 0) first[5] = $sformatf("h=%0d v=%0d got %0d want %0d", h, v, vram_address_out, ea);
        bad[5]++;
      end
      if (active === 1'b1)      act_cnt++;
      if (hsync === 1'b0)       hs_low++;
      if (vsync === 1'b0)       vs_low++;
      if (rgb === FG)           fg_cnt++;
      if (frame_start === 1'b1) fs_pos.push_back(p);
      if (v == wr_v && h == 50) mem[wr_row] = wr_val;
      p++;
    end
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (bad[k] !== 0) begin
        errors++;
        $display("FAIL %s_%s: %0d bad cycles, first %s", tag, nm[k], bad[k], first[k]);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int r = 0; r < 32; r++) mem[r] = 64'd0;
    mem[0] = 64'h0000_0000_0000_0001;
    for (int i = 0; i < 4; i++) begin
      @(posedge clock); #1;
      checks++;
      if ({hsync, vsync, rgb, active, frame_start, vram_address_out} !== {1'b1, 1'b1, 12'h000, 1'b0, 1'b0, 5'd0}) begin
        errors++;
        $display("FAIL reset_hold: got hs=%b vs=%b rgb=%h act=%b fs=%b addr=%0d want 1 1 000 0 0 0",
                 hsync, vsync, rgb, active, frame_start, vram_address_out);
      end
    end
    @(negedge clock);
    reset = 1'b1;
    model_reset();
  endtask

  task automatic test_first_frame();
    clear_counts();
    scan(HT * VT, -1, 0, 64'd0, "frame1");
    checks++;
    if (fs_pos.size() !== 1 || fs_pos[0] !== 0) begin
      errors++;
      $display("FAIL frame1_fs_first: got %0d pulses first at %0d want 1 pulse at 0",
               fs_pos.size(), (fs_pos.size() > 0) ? fs_pos[0] : -1);
    end
    checks++;
    if (act_cnt !== HV * VV) begin
      errors++; $display("FAIL frame1_active_count: got %0d want %0d", act_cnt, HV * VV);
    end
    checks++;
    if (hs_low !== HS * VT) begin
      errors++; $display("FAIL frame1_hsync_low: got %0d want %0d", hs_low, HS * VT);
    end
    checks++;
    if (vs_low !== VS * HT) begin
      errors++; $display("FAIL frame1_vsync_low: got %0d want %0d", vs_low, VS * HT);
    end
    checks++;
    if (fg_cnt !== SC * SC) begin
      errors++; $display("FAIL frame1_fg_pixels: got %0d want %0d", fg_cnt, SC * SC);
    end
  endtask

  // Random frame buffer; row 5 is rewritten mid-line on its first scan line,
  // so only the second line of that row shows the new data.
  task automatic test_random_frame();
    int exp_fg;
    logic [63:0] nv;
    for (int r = 0; r < 32; r++) mem[r] = {$urandom, $urandom};
    nv = ~mem[5];
    clear_counts();
    scan(HT * VT, VO + 5 * SC, 5, nv, "frame2");
    exp_fg = 0;
    for (int l = VO; l < VO + 32 * SC; l++) exp_fg += $countones(snap[l]) * SC;
    checks++;
    if (fs_pos.size() !== 1 || fs_pos[0] !== HT * VT) begin
      errors++;
      $display("FAIL frame2_fs_period: got %0d pulses first at %0d want 1 pulse at %0d",
               fs_pos.size(), (fs_pos.size() > 0) ? fs_pos[0] : -1, HT * VT);
    end
    checks++;
    if (fg_cnt !== exp_fg) begin
      errors++; $display("FAIL frame2_fg_pixels: got %0d want %0d", fg_cnt, exp_fg);
    end
    checks++;
    if (snap[VO + 5 * SC + 1] !== nv) begin
      errors++; $display("FAIL frame2_tear_row: model line data %h want %h", snap[VO + 5 * SC + 1], nv);
    end
  endtask

  task automatic test_async_reset();
    scan(40 * HT + 61, -1, 0, 64'd0, "prereset");
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({hsync, vsync, rgb, active, frame_start, vram_address_out} !== {1'b1, 1'b1, 12'h000, 1'b0, 1'b0, 5'd0}) begin
      errors++;
      $display("FAIL async_reset: got hs=%b vs=%b rgb=%h act=%b fs=%b addr=%0d want 1 1 000 0 0 0",
               hsync, vsync, rgb, active, frame_start, vram_address_out);
    end
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    model_reset();
    clear_counts();
    scan(12 * HT, -1, 0, 64'd0, "restart");
    checks++;
    if (fs_pos.size() !== 1 || fs_pos[0] !== 0) begin
      errors++;
      $display("FAIL restart_fs: got %0d pulses first at %0d want 1 pulse at 0",
               fs_pos.size(), (fs_pos.size() > 0) ? fs_pos[0] : -1);
    end
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_random_frame();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
